div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 25 ++
 rtl/div_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : div_ctrl_pkg                                            |
// | Brief    : Shared types and constants for the multi-cycle divider  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package div_ctrl_pkg;

  // Default operand width and the number of shift-subtract steps per divide
  localparam int c_DIV_WIDTH  = 32;
  localparam int c_ITER_COUNT = 32;

  // Width of the step counter; one spare bit above what 32 steps need
  localparam int c_CNT_W = 6;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : div_ctrl                                                |
// | Brief    : Restoring radix-2 DIV/DIVU unit, one quotient bit per   |
// |            cycle, with stall and annul handshake to the pipeline   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = c_DIV_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIV_WIDTH-1:0]     srca,
  input  logic [DIV_WIDTH-1:0]     srcb,
  input  logic                     signed_div,
  input  logic                     start,
  input  logic                     annul,
  output logic [2*DIV_WIDTH-1:0]   result,
  output logic                     ready,
  output logic                     stall_div
);

  // Counter value on the final shift-subtract step
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV_WIDTH - 1);

  div_state_e                state_q, state_d;
  logic [c_CNT_W-1:0]        cnt_q, cnt_d;
  // {remainder, quotient} working register; remainder part is one bit wider
  logic [2*DIV_WIDTH:0]      rq_q, rq_d;
  logic [DIV_WIDTH-1:0]      dvs_q, dvs_d;
  logic                      negq_q, negq_d;
  logic                      negr_q, negr_d;
  logic [2*DIV_WIDTH-1:0]    res_q, res_d;

  // Operand magnitudes for the signed case
  logic                      w_neg_a;
  logic                      w_neg_b;
  logic [DIV_WIDTH-1:0]      w_abs_a;
  logic [DIV_WIDTH-1:0]      w_abs_b;

  // One restoring step: shifted partial remainder against the divisor
  logic [DIV_WIDTH+1:0]      w_cand;
  logic                      w_ge;
  logic [DIV_WIDTH:0]        w_diff;
  logic [2*DIV_WIDTH:0]      w_step;
  logic [DIV_WIDTH-1:0]      w_quot;
  logic [DIV_WIDTH-1:0]      w_rem;
  logic [DIV_WIDTH-1:0]      w_quot_fix;
  logic [DIV_WIDTH-1:0]      w_rem_fix;
  // Top remainder bit is always zero after a step since rem < divisor
  logic                      w_unused_top;

  assign w_neg_a = signed_div & srca[DIV_WIDTH-1];
  assign w_neg_b = signed_div & srcb[DIV_WIDTH-1];
  assign w_abs_a = w_neg_a ? -srca : srca;
  assign w_abs_b = w_neg_b ? -srcb : srcb;

  assign w_cand       = rq_q[2*DIV_WIDTH:DIV_WIDTH-1];
  assign w_ge         = (w_cand >= {2'b00, dvs_q});
  assign w_diff       = w_cand[DIV_WIDTH:0] - {1'b0, dvs_q};
  assign w_step       = w_ge ? {w_diff, rq_q[DIV_WIDTH-2:0], 1'b1}
                             : {w_cand[DIV_WIDTH:0], rq_q[DIV_WIDTH-2:0], 1'b0};
  assign w_quot       = w_step[DIV_WIDTH-1:0];
  assign w_rem        = w_step[2*DIV_WIDTH-1:DIV_WIDTH];
  assign w_unused_top = w_step[2*DIV_WIDTH];
  assign w_quot_fix   = negq_q ? -w_quot : w_quot;
  assign w_rem_fix    = negr_q ? -w_rem : w_rem;

  // Ready is suppressed by a same-cycle annul; result is only visible in END
  assign ready     = (state_q == END) & ~annul;
  assign result    = (state_q == END) ? res_q : '0;
  assign stall_div = start & ~ready & ~annul;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rq_q    <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rq_q    <= rq_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  // Next-state and datapath update; annul overrides every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          res_d = '0;
          if (srcb == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d = ON;
            cnt_d   = '0;
            rq_d    = {{(DIV_WIDTH+1){1'b0}}, w_abs_a};
            dvs_d   = w_abs_b;
            negq_d  = w_neg_a ^ w_neg_b;
            negr_d  = w_neg_a;
          end
        end
      end
      DIVZERO: begin
        state_d = END;
        res_d   = '0;
      end
      ON: begin
        rq_d  = w_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_LAST) begin
          state_d = END;
          res_d   = {w_rem_fix, w_quot_fix};
        end
      end
      END: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (annul) begin
      state_d = IDLE;
      res_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_div_ctrl                                             |
// | Brief    : Self-checking bench for div_ctrl: directed vector table,|
// |            randomized divides against an arithmetic model, and     |
// |            annul / reset corner sequences                          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        signed_div;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_div;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  div_ctrl #(.DIV_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .srca       (srca),
    .srcb       (srcb),
    .signed_div (signed_div),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_div  (stall_div)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Arithmetic reference: magnitude divide, then apply signs, wrap to 32 bits
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] lo, output logic [31:0] hi, output int lat);
    longint ma, mb, q, r;
    logic   na, nb;
    if (b == 32'd0) begin
      lo = '0; hi = '0; lat = 2;
      return;
    end
    na = s & a[31];
    nb = s & b[31];
    ma = na ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
    mb = nb ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    lo  = q[31:0];
    hi  = r[31:0];
    lat = c_ITER_COUNT + 1;
  endtask

  // Entered just after a falling edge (cycle 0); leaves just after a falling edge
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] lo, input logic [31:0] hi, input int lat,
                         input bit perturb);
    srca = a; srcb = b; signed_div = s; start = 1'b1; annul = 1'b0;
    #1;
    chk("c0_ready_stall", {63'd0, ready, stall_div}, 65'b01);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (perturb && k == 5) begin
        srca = $urandom; srcb = $urandom; signed_div = ~s;
      end
      #1;
      chk("busy_ready_stall", {63'd0, ready, stall_div}, 65'b01);
    end
    @(negedge clk); #1;
    chk("done_ready_stall", {63'd0, ready, stall_div}, 65'b10);
    chk("done_result", {1'b0, result}, {1'b0, hi, lo});
    repeat (2) begin
      @(negedge clk); #1;
      chk("hold_end", {ready, result}, {1'b1, hi, lo});
    end
    start = 1'b0;
    @(negedge clk); #1;
    chk("back_idle", {ready, result}, 65'd0);
  endtask

  initial begin
    logic [31:0] a, b, lo, hi;
    logic        s;
    int          lat;

    rst = 1'b1; srca = '0; srcb = '0; signed_div = 1'b0; start = 1'b0; annul = 1'b0;

    // Directed vectors, expected values written out by hand
    vecs[0] = '{32'd100,      32'd7,          1'b0, 32'd14,       32'd2,          33};
    vecs[1] = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF,   33};
    vecs[2] = '{32'd5,        32'd0,          1'b0, 32'd0,        32'd0,          2};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,          33};
    vecs[4] = '{32'hFFFFFFFF, 32'd1,          1'b0, 32'hFFFFFFFF, 32'd0,          33};
    vecs[5] = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1,          33};
    vecs[6] = '{32'hFFFFFFF9, 32'hFFFFFFFE,   1'b1, 32'd3,        32'hFFFFFFFF,   33};
    vecs[7] = '{32'hFFFFFFF9, 32'd2,          1'b0, 32'h7FFFFFFC, 32'd1,          33};

    // Reset state, and stall follows start while in reset
    @(negedge clk); #1;
    chk("rst_outputs", {ready, result}, 65'd0);
    chk("rst_stall_lo", {64'd0, stall_div}, 65'd0);
    start = 1'b1; #1;
    chk("rst_stall_hi", {64'd0, stall_div}, 65'd1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;

    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lo, vecs[i].hi, vecs[i].lat, (i % 2) == 1);

    // Randomized operands against the arithmetic model
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = (n % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (n % 4 == 1) b = b >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      model(a, b, s, lo, hi, lat);
      run_div(a, b, s, lo, hi, lat, (n % 2) == 0);
    end

    // Annul at cycle 10: no ready pulse, then a fresh divide from cycle 12
    srca = 32'd100; srcb = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      chk("pre_annul_ready", {64'd0, ready}, 65'd0);
    end
    annul = 1'b1; #1;
    chk("annul_outputs", {63'd0, ready, stall_div}, 65'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0; #1;
    chk("annul_idle", {ready, result}, 65'd0);
    @(negedge clk); #1;
    model(32'd9, 32'd3, 1'b0, lo, hi, lat);
    run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, lat, 1'b0);

    // Reset at cycle 20 abandons the divide; a new one runs full length
    srca = 32'd100; srcb = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; start = 1'b0; #1;
    chk("midrst_outputs", {ready, result}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0);

    // Reset while ready is high must clear it without waiting for an edge
    srca = 32'd100; srcb = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (33) @(negedge clk);
    #1;
    chk("pre_rst_ready", {ready, result}, {1'b1, 32'd2, 32'd14});
    #1 rst = 1'b1; #1;
    chk("async_rst_clear", {ready, result}, 65'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
